// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_sel.sv
// Combinational 4:1 data selector used by the arbiter's capture path.
module mux4_sel
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      2'd3:    y = d;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four requesters with a registered 4:1 data mux.
// Optional grant timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   y,
  output logic               valid
);

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_max_check
    $error("HOLD_MAX must fit the 4-bit hold counter (1..15)");
  end

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  winner;
  logic [WIDTH-1:0]  mux_y;
  logic              hold_done;

  mux4_sel #(.WIDTH(WIDTH)) u_sel (
    .sel (sel),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .y   (mux_y)
  );

  // Scan from farthest to nearest so the nearest set bit after ptr wins last.
  always_comb begin
    winner = ptr;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (req[ptr + SEL_W'(k)]) winner = ptr + SEL_W'(k);
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [3:0] hold_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

  assign hold_done = (hold_cnt == 4'(HOLD_MAX));
`else
  assign hold_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      y     <= '0;
      valid <= 1'b0;
      ptr   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (|req) begin
            gnt   <= NUM_REQ'(1) << winner;
            sel   <= winner;
            ptr   <= winner;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[sel] || hold_done) begin
            gnt   <= '0;
            valid <= 1'b0;
            state <= IDLE;
          end else begin
            y     <= mux_y;
            valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
